// File: rtl/int_accept_unit.sv
// int_accept_unit: accepts one pending interrupt at an instruction commit
// boundary. It flushes the pipeline, redirects fetch to the handler vector,
// tracks handler execution, and redirects back to the saved return PC once the
// handler's return instruction commits.
// Optional feature: define INT_LAT_STATS_EN to enable the interrupt count and
// worst-case acceptance-to-redirect latency statistics.
module int_accept_unit #(
    parameter int LAT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signal_interrupt,
    input  logic [31:0]          interrupt_PC,
    output logic                 interrupt_serviced,
    input  logic                 int_enable,
    input  logic                 commit_valid,
    input  logic [31:0]          commit_pc,
    input  logic                 mret_valid,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    input  logic                 redirect_ready,
    output logic [31:0]          epc,
    output logic                 in_handler,
    output logic [LAT_WIDTH-1:0] int_count,
    output logic [LAT_WIDTH-1:0] lat_max
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BOUNDARY,
        ST_REDIRECT,
        ST_HANDLER,
        ST_RETURN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] vec_pc_q, vec_pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic        flush_q, flush_d;
    logic        serviced_q, serviced_d;
    logic        in_handler_q, in_handler_d;

    logic        accept;
    logic        vector_handshake;

    // Acceptance is only possible from IDLE; the vector handshake completes the redirect.
    assign accept           = (state_q == ST_IDLE) && signal_interrupt && int_enable;
    assign vector_handshake = (state_q == ST_REDIRECT) && redirect_ready;

    // Next-state and next-output logic; pulses default low, levels hold.
    always_comb begin
        state_d          = state_q;
        vec_pc_d         = vec_pc_q;
        epc_d            = epc_q;
        redirect_pc_d    = redirect_pc_q;
        redirect_valid_d = redirect_valid_q;
        flush_d          = 1'b0;
        serviced_d       = 1'b0;
        in_handler_d     = in_handler_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    vec_pc_d = interrupt_PC;
                    state_d  = ST_WAIT_BOUNDARY;
                end
            end
            ST_WAIT_BOUNDARY: begin
                if (commit_valid) begin
                    epc_d            = commit_pc;
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = vec_pc_q;
                    state_d          = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    in_handler_d     = 1'b1;
                    state_d          = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (mret_valid) begin
                    serviced_d       = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = epc_q;
                    state_d          = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    in_handler_d     = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            default: begin
                redirect_valid_d = 1'b0;
                in_handler_d     = 1'b0;
                state_d          = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset returns everything to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            vec_pc_q         <= '0;
            epc_q            <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            serviced_q       <= 1'b0;
            in_handler_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            vec_pc_q         <= vec_pc_d;
            epc_q            <= epc_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            serviced_q       <= serviced_d;
            in_handler_q     <= in_handler_d;
        end
    end

    assign flush              = flush_q;
    assign redirect_valid     = redirect_valid_q;
    assign redirect_pc        = redirect_pc_q;
    assign epc                = epc_q;
    assign in_handler         = in_handler_q;
    assign interrupt_serviced = serviced_q;

`ifdef INT_LAT_STATS_EN
    localparam logic [LAT_WIDTH-1:0] LAT_ONE = {{(LAT_WIDTH-1){1'b0}}, 1'b1};

    logic [LAT_WIDTH-1:0] int_count_q, int_count_d;
    logic [LAT_WIDTH-1:0] lat_cnt_q, lat_cnt_d;
    logic [LAT_WIDTH-1:0] lat_max_q, lat_max_d;
    logic [LAT_WIDTH-1:0] lat_total;

    // Latency counts clock edges from acceptance to the vector handshake; all counters saturate.
    always_comb begin
        int_count_d = int_count_q;
        lat_cnt_d   = lat_cnt_q;
        lat_max_d   = lat_max_q;
        lat_total   = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + LAT_ONE;
        if (accept) begin
            lat_cnt_d = '0;
        end else if ((state_q == ST_WAIT_BOUNDARY) || (state_q == ST_REDIRECT)) begin
            lat_cnt_d = lat_total;
        end
        if (vector_handshake) begin
            if (!(&int_count_q)) begin
                int_count_d = int_count_q + LAT_ONE;
            end
            if (lat_total > lat_max_q) begin
                lat_max_d = lat_total;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_count_q <= '0;
            lat_cnt_q   <= '0;
            lat_max_q   <= '0;
        end else begin
            int_count_q <= int_count_d;
            lat_cnt_q   <= lat_cnt_d;
            lat_max_q   <= lat_max_d;
        end
    end

    assign int_count = int_count_q;
    assign lat_max   = lat_max_q;
`else
    assign int_count = '0;
    assign lat_max   = '0;
`endif

endmodule

// File: tb/tb_int_accept_unit.sv
// Testbench for int_accept_unit: directed scenarios with a scoreboard monitor.
// Expected flush/redirect/serviced events are queued by the stimulus and
// popped by a negedge monitor whenever the DUT presents one.
module tb_int_accept_unit;

   localparam int LW = 16;
   localparam logic [1:0] EV_FLUSH = 2'd0;
   localparam logic [1:0] EV_REDIR = 2'd1;
   localparam logic [1:0] EV_SERV  = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] value;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          signal_interrupt;
   logic [31:0]   interrupt_PC;
   logic          interrupt_serviced;
   logic          int_enable;
   logic          commit_valid;
   logic [31:0]   commit_pc;
   logic          mret_valid;
   logic          flush;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          redirect_ready;
   logic [31:0]   epc;
   logic          in_handler;
   logic [LW-1:0] int_count;
   logic [LW-1:0] lat_max;

   exp_t sbQ[$];
   int   testsRun = 0;
   int   failures = 0;

   int_accept_unit #(.LAT_WIDTH(LW)) dut (
      .clk                (clk),
      .rst                (rst),
      .signal_interrupt   (signal_interrupt),
      .interrupt_PC       (interrupt_PC),
      .interrupt_serviced (interrupt_serviced),
      .int_enable         (int_enable),
      .commit_valid       (commit_valid),
      .commit_pc          (commit_pc),
      .mret_valid         (mret_valid),
      .flush              (flush),
      .redirect_valid     (redirect_valid),
      .redirect_pc        (redirect_pc),
      .redirect_ready     (redirect_ready),
      .epc                (epc),
      .in_handler         (in_handler),
      .int_count          (int_count),
      .lat_max            (lat_max)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drive every DUT input at once
   task automatic applyStimulus(input logic sig, input logic en, input logic [31:0] ipc,
                                input logic cv, input logic [31:0] cpc,
                                input logic mret, input logic rdy);
      signal_interrupt = sig;
      int_enable       = en;
      interrupt_PC     = ipc;
      commit_valid     = cv;
      commit_pc        = cpc;
      mret_valid       = mret;
      redirect_ready   = rdy;
   endtask

   // Advance n rising edges and settle just after the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pushExpect(input logic [1:0] kind, input logic [31:0] value);
      exp_t e;
      e.kind  = kind;
      e.value = value;
      sbQ.push_back(e);
   endtask

   // Pop the oldest expected event and compare it with what the DUT presented
   task automatic scoreboardPop(input logic [1:0] kind, input logic [31:0] value, input string name);
      exp_t e;
      testsRun++;
      if (sbQ.size() == 0) begin
         failures++;
         $display("[TB] FAIL unexpected_%s: got kind %0d value 0x%08h expected no event", name, kind, value);
      end else begin
         e = sbQ.pop_front();
         if (e.kind !== kind || e.value !== value) begin
            failures++;
            $display("[TB] FAIL %s: got kind %0d value 0x%08h expected kind %0d value 0x%08h",
                     name, kind, value, e.kind, e.value);
         end
      end
   endtask

   // Monitor: every DUT output event must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (flush) scoreboardPop(EV_FLUSH, epc, "flush_epc");
         if (interrupt_serviced) scoreboardPop(EV_SERV, 32'h0, "serviced");
         if (redirect_valid && redirect_ready) scoreboardPop(EV_REDIR, redirect_pc, "redirect_pc");
      end
   end

   // Directed scenarios
   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
      #1 rst = 1'b0;
      #1;
      checkOutput("rst_flush", 32'(flush), 32'h0);
      checkOutput("rst_redirect_valid", 32'(redirect_valid), 32'h0);
      checkOutput("rst_serviced", 32'(interrupt_serviced), 32'h0);
      checkOutput("rst_in_handler", 32'(in_handler), 32'h0);
      checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
      checkOutput("rst_epc", epc, 32'h0);
      checkOutput("rst_int_count", 32'(int_count), 32'h0);
      checkOutput("rst_lat_max", 32'(lat_max), 32'h0);
      tick(2);
      rst = 1'b1;
      tick(1);

      // Basic service: accept, boundary three cycles later, handler, return
      applyStimulus(1, 1, 32'h0000_4000, 0, 32'h0, 0, 1);
      tick(1);
      applyStimulus(0, 1, 32'h0, 0, 32'h0, 0, 1);
      checkOutput("basic_no_early_flush", 32'(flush), 32'h0);
      tick(2);
      pushExpect(EV_FLUSH, 32'h0000_1234);
      pushExpect(EV_REDIR, 32'h0000_4000);
      applyStimulus(0, 1, 32'h0, 1, 32'h0000_1234, 0, 1);
      tick(1);
      applyStimulus(0, 1, 32'h0, 0, 32'h0, 0, 1);
      checkOutput("basic_flush", 32'(flush), 32'h1);
      checkOutput("basic_epc", epc, 32'h0000_1234);
      checkOutput("basic_vector_pc", redirect_pc, 32'h0000_4000);
      tick(1);
      checkOutput("basic_in_handler", 32'(in_handler), 32'h1);
      checkOutput("basic_flush_done", 32'(flush), 32'h0);
      tick(19);
      pushExpect(EV_SERV, 32'h0);
      pushExpect(EV_REDIR, 32'h0000_1234);
      applyStimulus(0, 1, 32'h0, 0, 32'h0, 1, 1);
      tick(1);
      applyStimulus(0, 1, 32'h0, 0, 32'h0, 0, 1);
      checkOutput("basic_serviced", 32'(interrupt_serviced), 32'h1);
      checkOutput("basic_return_pc", redirect_pc, 32'h0000_1234);
      tick(1);
      checkOutput("basic_serviced_done", 32'(interrupt_serviced), 32'h0);
      checkOutput("basic_left_handler", 32'(in_handler), 32'h0);

      // Masking: pending but disabled interrupt with commits must be ignored
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 0, 32'h0000_8000, 1, 32'h0000_DEAD, 0, 0);
         tick(1);
         checkOutput("mask_flush", 32'(flush), 32'h0);
         checkOutput("mask_redirect_valid", 32'(redirect_valid), 32'h0);
      end
      // Enable: accepted at next edge; commit in the acceptance cycle is not the boundary
      applyStimulus(1, 1, 32'h0000_8000, 1, 32'h0000_DEAD, 0, 0);
      tick(1);
      checkOutput("accept_same_cycle_commit", 32'(flush), 32'h0);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
      tick(2);
      pushExpect(EV_FLUSH, 32'h0000_2000);
      pushExpect(EV_REDIR, 32'h0000_8000);
      applyStimulus(0, 0, 32'h0, 1, 32'h0000_2000, 0, 0);
      tick(1);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0);
      checkOutput("mask_late_flush", 32'(flush), 32'h1);
      checkOutput("mask_epc", epc, 32'h0000_2000);

      // Backpressure: redirect must hold stable while ready is low
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_valid_hold", 32'(redirect_valid), 32'h1);
         checkOutput("bp_pc_hold", redirect_pc, 32'h0000_8000);
         checkOutput("bp_not_handler", 32'(in_handler), 32'h0);
         tick(1);
      end
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1);
      tick(1);
      checkOutput("bp_in_handler", 32'(in_handler), 32'h1);
      checkOutput("bp_valid_drop", 32'(redirect_valid), 32'h0);
`ifdef INT_LAT_STATS_EN
      checkOutput("stats_int_count", 32'(int_count), 32'd2);
      checkOutput("stats_lat_max", 32'(lat_max), 32'd9);
`else
      checkOutput("stats_off_int_count", 32'(int_count), 32'd0);
      checkOutput("stats_off_lat_max", 32'(lat_max), 32'd0);
`endif

      // Spurious interrupt while in the handler
      applyStimulus(1, 1, 32'h0000_BAD0, 0, 32'h0, 0, 1);
      tick(5);
      checkOutput("spur_int_in_handler", 32'(in_handler), 32'h1);
      checkOutput("spur_int_no_redirect", 32'(redirect_valid), 32'h0);
      checkOutput("spur_int_no_service", 32'(interrupt_serviced), 32'h0);
      pushExpect(EV_SERV, 32'h0);
      pushExpect(EV_REDIR, 32'h0000_2000);
      applyStimulus(0, 1, 32'h0, 0, 32'h0, 1, 1);
      tick(1);
      applyStimulus(0, 1, 32'h0, 0, 32'h0, 0, 1);
      checkOutput("spur_return_pc", redirect_pc, 32'h0000_2000);
      tick(1);
      checkOutput("spur_back_idle", 32'(in_handler), 32'h0);

      // Spurious mret while idle
      applyStimulus(0, 1, 32'h0, 0, 32'h0, 1, 1);
      tick(3);
      checkOutput("spur_mret_no_service", 32'(interrupt_serviced), 32'h0);
      checkOutput("spur_mret_no_handler", 32'(in_handler), 32'h0);
      checkOutput("spur_mret_no_redirect", 32'(redirect_valid), 32'h0);

      // Reset during REDIRECT
      applyStimulus(1, 1, 32'h0000_C000, 0, 32'h0, 0, 0);
      tick(1);
      pushExpect(EV_FLUSH, 32'h0000_3000);
      applyStimulus(0, 1, 32'h0, 1, 32'h0000_3000, 0, 0);
      tick(1);
      applyStimulus(0, 1, 32'h0, 0, 32'h0, 0, 0);
      checkOutput("mid_flush", 32'(flush), 32'h1);
      tick(1);
      checkOutput("mid_redirect_before_rst", 32'(redirect_valid), 32'h1);
      #2 rst = 1'b0;
      #1;
      checkOutput("mid_rst_redirect_valid", 32'(redirect_valid), 32'h0);
      checkOutput("mid_rst_epc", epc, 32'h0);
      checkOutput("mid_rst_redirect_pc", redirect_pc, 32'h0);
      checkOutput("mid_rst_in_handler", 32'(in_handler), 32'h0);
      checkOutput("mid_rst_int_count", 32'(int_count), 32'h0);
      checkOutput("mid_rst_lat_max", 32'(lat_max), 32'h0);
      applyStimulus(0, 1, 32'h0, 1, 32'h0000_7000, 0, 1);
      tick(1);
      rst = 1'b1;
      tick(2);
      checkOutput("post_rst_idle_no_flush", 32'(flush), 32'h0);

      // Fresh sequence after reset proves the FSM restarted from IDLE
      applyStimulus(1, 1, 32'h0000_5000, 0, 32'h0, 0, 1);
      tick(1);
      pushExpect(EV_FLUSH, 32'h0000_6000);
      pushExpect(EV_REDIR, 32'h0000_5000);
      applyStimulus(0, 0, 32'h0, 1, 32'h0000_6000, 0, 1);
      tick(1);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1);
      checkOutput("post_rst_epc", epc, 32'h0000_6000);
      tick(1);
      checkOutput("post_rst_in_handler", 32'(in_handler), 32'h1);
`ifdef INT_LAT_STATS_EN
      checkOutput("post_rst_int_count", 32'(int_count), 32'd1);
      checkOutput("post_rst_lat_max", 32'(lat_max), 32'd2);
`endif
      pushExpect(EV_SERV, 32'h0);
      pushExpect(EV_REDIR, 32'h0000_6000);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 1);
      tick(1);
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 1);
      tick(1);
      checkOutput("post_rst_done", 32'(in_handler), 32'h0);

      tick(3);
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
